cpu5_ifu: RTL and testbench

//  Decoupled, parametrised instruction fetch unit for the next-generation cpu5 core.

---
 rtl/cpu5_ifu_pkg.sv | 8 +
 rtl/cpu5_ifu_fifo.sv | 38 +++
 rtl/cpu5_ifu.sv | 85 ++++++++
 tb/tb_cpu5_ifu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu5_ifu_pkg.sv
// cpu5_ifu_pkg: shared constants for the cpu5 instruction fetch unit
package cpu5_ifu_pkg;
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam int PC_INC = 4;
  localparam int DEF_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;
endpackage

// File: rtl/cpu5_ifu_fifo.sv
// cpu5_ifu_fifo: sync prefetch FIFO with flush and occupancy count
module cpu5_ifu_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  assign dout = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/cpu5_ifu.sv
// cpu5_ifu: decoupled fetch unit with prefetch buffer and redirect/stale-discard.
// Define CPU5_IFU_BYPASS_EN to present a response to decode in its arrival cycle when the buffer is empty.
module cpu5_ifu
  import cpu5_ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] ifu_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [0:0] state;
  logic [XLEN-1:0] fetch_pc, rsp_pc, new_pc;
  logic [CW-1:0] outstanding, stale, count, out_nxt, stale_dec;
  logic acc, push, pop, empty, byp, fetching;
  logic [2*XLEN-1:0] head;
  assign fetching = state == ST_FETCH;
  assign new_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = reset && fetching && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign acc = imem_req_valid && imem_req_ready;
  assign out_nxt = outstanding + CW'(acc) - CW'(imem_rsp_valid);
  assign stale_dec = stale - CW'(imem_rsp_valid);
`ifdef CPU5_IFU_BYPASS_EN
  assign byp = empty && fetching && !redirect_valid && imem_rsp_valid;
`else
  assign byp = 1'b0;
`endif
  assign push = imem_rsp_valid && fetching && !redirect_valid && !(byp && ifu_ready);
  assign pop = !empty && ifu_ready;
  assign ifu_valid = !empty || byp;
  assign ifu_pc = byp ? rsp_pc : empty ? '0 : head[2*XLEN-1:XLEN];
  assign ifu_instr = byp ? imem_rsp_data : empty ? '0 : head[XLEN-1:0];
  assign busy = outstanding != '0 || !empty;
  cpu5_ifu_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .din({rsp_pc, imem_rsp_data}),
    .dout(head),
    .empty(empty),
    .count(count)
  );
  // stale always equals the in-flight count on entering DRAIN, so the drain ends exactly when memory goes quiet
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_FETCH;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      stale <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= new_pc;
        rsp_pc <= new_pc;
      end else begin
        if (acc) fetch_pc <= fetch_pc + XLEN'(PC_INC);
        if (imem_rsp_valid && fetching) rsp_pc <= rsp_pc + XLEN'(PC_INC);
      end
      if (!fetching) begin
        stale <= stale_dec;
        state <= stale_dec == '0 ? ST_FETCH : ST_DRAIN;
      end else if (redirect_valid) begin
        stale <= out_nxt;
        state <= out_nxt != '0 ? ST_DRAIN : ST_FETCH;
      end
    end
endmodule

// File: tb/tb_cpu5_ifu.sv
// tb_cpu5_ifu: directed bench for cpu5_ifu with a queued in-order memory model and pc scoreboard
module tb_cpu5_ifu;
`ifdef CPU5_IFU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, ifu_valid, ifu_ready, redirect_valid, busy;
  logic [31:0] imem_req_addr, imem_rsp_data, ifu_pc, ifu_instr, redirect_pc;
  logic [31:0] exp_req, exp_pc, last_pc;
  logic [31:0] q[$];
  logic hold;
  int errors = 0, checks = 0, acc_total = 0, del_total = 0, d0, n;
  always #5 clk = ~clk;
  cpu5_ifu dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_pc(ifu_pc), .ifu_instr(ifu_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive_rsp();
    imem_rsp_valid = !hold && q.size() > 0;
    imem_rsp_data = q.size() > 0 ? mem_f(q[0]) : 32'h0;
  endtask
  task automatic mem_hold(input logic v);
    hold = v;
    drive_rsp();
  endtask
  task automatic cyc();
    logic a, r;
    logic [31:0] ad;
    a = imem_req_valid && imem_req_ready;
    ad = imem_req_addr;
    r = imem_rsp_valid;
    if (a) begin
      check("req_addr", ad, exp_req);
      exp_req += 4;
      acc_total++;
    end
    if (ifu_valid && ifu_ready) begin
      check("ifu_pc", ifu_pc, exp_pc);
      check("ifu_instr", ifu_instr, mem_f(exp_pc));
      last_pc = ifu_pc;
      exp_pc += 4;
      del_total++;
    end
    if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (r) void'(q.pop_front());
    if (a) q.push_back(ad);
    drive_rsp();
  endtask
  task automatic wait_del(input int k, input string tag);
    d0 = del_total;
    n = 0;
    while (del_total < d0 + k && n < 40) begin
      cyc();
      n++;
    end
    check(tag, 32'(del_total - d0), 32'(k));
  endtask
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    imem_req_ready = 1'b1;
    ifu_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exp_req = '0;
    exp_pc = '0;
    last_pc = '0;
    mem_hold(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_ifu_valid", 32'(ifu_valid), 0);
    check("rst_ifu_pc", ifu_pc, 0);
    check("rst_ifu_instr", ifu_instr, 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    #1;
    check("t1_req_valid", 32'(imem_req_valid), 1);
    check("t1_req_addr", imem_req_addr, 32'h0);
    cyc();
    check("t1_latency", 32'(ifu_valid), 32'(BYP));
    cyc();
    check("t1_valid", 32'(ifu_valid), 1);
    repeat (10) cyc();
    check("t1_stream", 32'(ifu_valid), 1);
    ifu_ready = 1'b0;
    repeat (8) cyc();
    check("t2_credit_stop", 32'(imem_req_valid), 0);
    check("t2_buffered", 32'(acc_total - del_total), 4);
    check("t2_busy", 32'(busy), 1);
    ifu_ready = 1'b1;
    cyc();
    check("t2_resume", 32'(imem_req_valid), 1);
    repeat (6) cyc();
    imem_req_ready = 1'b0;
    repeat (6) cyc();
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(ifu_valid), 0);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    check("t6_rsp_cycle", 32'(ifu_valid), 32'(BYP));
    cyc();
    check("t6_next_cycle", 32'(ifu_valid), 32'(!BYP));
    cyc();
    check("t6_idle", 32'(busy), 0);
    mem_hold(1'b1);
    imem_req_ready = 1'b1;
    repeat (3) cyc();
    imem_req_ready = 1'b0;
    check("t3_busy", 32'(busy), 1);
    redirect(32'h100);
    check("t3_drain", 32'(imem_req_valid), 0);
    check("t3_addr", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    mem_hold(1'b0);
    cyc();
    check("t3_still_drain", 32'(imem_req_valid), 0);
    wait_del(1, "t3_deliver");
    check("t3_first_pc", last_pc, 32'h100);
    repeat (4) cyc();
    ifu_ready = 1'b0;
    cyc();
    ifu_ready = 1'b1;
    check("t4_pre", {30'd0, ifu_valid, imem_req_valid}, 32'h3);
    d0 = del_total;
    redirect(32'h200);
    check("t4_handshake_once", 32'(del_total - d0), 1);
    check("t4_stale_drain", 32'(imem_req_valid), 0);
    wait_del(1, "t4_deliver");
    check("t4_first_pc", last_pc, 32'h200);
    repeat (3) cyc();
    redirect(32'hFFFF_FFF8);
    wait_del(3, "t5_deliver");
    check("t5_wrap_pc", last_pc, 32'h0);
    redirect(32'h103);
    check("t5_align", imem_req_addr, 32'h100);
    wait_del(1, "t5_deliver2");
    check("t5_first_pc", last_pc, 32'h100);
    imem_req_ready = 1'b0;
    repeat (8) cyc();
    check("end_busy", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
